// File: rtl/xor_descrambler_if.sv
// Word-stream bundle for the descrambler: scrambled words in, plaintext words out.
// Both directions use a valid/ready handshake.
interface xor_descrambler_if #(
   parameter int N = 32
);
   logic         in_valid;
   logic [N-1:0] in_data;
   logic         in_ready;
   logic         out_valid;
   logic [N-1:0] out_data;
   logic         out_ready;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/xor_descrambler.sv
// Additive descrambler. A 32-bit Galois LFSR regenerates the transmitter keystream,
// and each accepted word is XORed with it into a registered valid/ready output stage.
module xor_descrambler #(
   parameter int          N     = 32,
   parameter logic [31:0] TAPS  = 32'h80200003,
   parameter int          CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seed_valid,
   input  logic [31:0]      seed,
   xor_descrambler_if.slave stream,
   output logic             locked,
   output logic [CNT_W-1:0] word_count
);

   typedef enum logic {UNSEEDED, RUN} state_t;

   state_t       state;
   logic [31:0]  lfsr;
   logic         out_valid;
   logic [N-1:0] out_data;
   logic         in_ready;
   logic         accept;

   // A seed load takes the cycle, so the source holds its word.
   assign in_ready = locked && !seed_valid && (!out_valid || stream.out_ready);
   assign accept   = stream.in_valid && in_ready;

   assign stream.in_ready  = in_ready;
   assign stream.out_valid = out_valid;
   assign stream.out_data  = out_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= UNSEEDED;
         lfsr       <= 32'h00000001;
         out_valid  <= 1'b0;
         out_data   <= '0;
         locked     <= 1'b0;
         word_count <= '0;
      end else begin
         if (out_valid && stream.out_ready)
            out_valid <= 1'b0;

         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= stream.in_data ^ lfsr[N-1:0];
            lfsr      <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'h0);
            if (word_count != {CNT_W{1'b1}})
               word_count <= word_count + 1'b1;
         end

         // An all-zero seed would lock the LFSR at zero forever.
         if (seed_valid) begin
            lfsr       <= (seed == 32'h0) ? 32'h00000001 : seed;
            word_count <= '0;
            locked     <= 1'b1;
         end

         case (state)
            UNSEEDED: if (seed_valid) state <= RUN;
            RUN:      state <= RUN;
            default:  state <= UNSEEDED;
         endcase
      end
   end

endmodule

// File: tb/tb_xor_descrambler.sv
// Directed bench for xor_descrambler with hand-computed keystream values.
module tb_xor_descrambler;

   localparam int N     = 32;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             seed_valid;
   logic [31:0]      seed;
   logic             locked;
   logic [CNT_W-1:0] word_count;
   int               n_cmp = 0;
   int               n_err = 0;

   xor_descrambler_if #(.N(N)) stream ();

   xor_descrambler #(.N(N), .TAPS(32'h80200003), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .seed_valid (seed_valid),
      .seed       (seed),
      .stream     (stream.slave),
      .locked     (locked),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic seed_load(input logic [31:0] s);
      seed_valid      = 1'b1;
      seed            = s;
      stream.in_valid = 1'b0;
      #1 chk("seed_in_ready", 32'(stream.in_ready), 32'd0);
      @(negedge clk);
      seed_valid = 1'b0;
      chk("seed_locked", 32'(locked), 32'd1);
      chk("seed_count", 32'(word_count), 32'd0);
   endtask

   // Offer one word; the descrambled result must appear one cycle later.
   task automatic xfer(input string tag, input logic [31:0] d, input logic [31:0] exp);
      stream.in_valid = 1'b1;
      stream.in_data  = d;
      #1 chk({tag, "_in_ready"}, 32'(stream.in_ready), 32'd1);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(stream.out_valid), 32'd1);
      chk({tag, "_data"}, stream.out_data, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst              = 1'b1;
      seed_valid       = 1'b0;
      seed             = 32'h0;
      stream.in_valid  = 1'b0;
      stream.in_data   = 32'h0;
      stream.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(stream.out_valid), 32'd0);
      chk("rst_out_data", stream.out_data, 32'h0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_count", 32'(word_count), 32'd0);
      chk("rst_in_ready", 32'(stream.in_ready), 32'd0);
      rst = 1'b0;

      // Unseeded: words are refused.
      stream.in_valid = 1'b1;
      stream.in_data  = 32'hFFFFFFFF;
      for (int i = 0; i < 5; i++) begin
         #1 chk("unseeded_in_ready", 32'(stream.in_ready), 32'd0);
         @(negedge clk);
         chk("unseeded_out_valid", 32'(stream.out_valid), 32'd0);
         chk("unseeded_locked", 32'(locked), 32'd0);
      end

      // Seed 1, three back-to-back words.
      seed_load(32'h00000001);
      xfer("s1_w0", 32'hFFFFFFFF, 32'hFFFFFFFE);
      xfer("s1_w1", 32'hFFFFFFFF, 32'h7FDFFFFC);
      xfer("s1_w2", 32'h00000000, 32'hC0300002);
      stream.in_valid = 1'b0;
      @(negedge clk);
      chk("s1_drain_valid", 32'(stream.out_valid), 32'd0);
      chk("s1_drain_data", stream.out_data, 32'hC0300002);
      chk("s1_count", 32'(word_count), 32'd3);

      // Seed 0 is replaced by 1.
      seed_load(32'h00000000);
      xfer("s0_w0", 32'hFFFFFFFF, 32'hFFFFFFFE);
      xfer("s0_w1", 32'hFFFFFFFF, 32'h7FDFFFFC);
      xfer("s0_w2", 32'h00000000, 32'hC0300002);
      stream.in_valid = 1'b0;
      chk("s0_locked", 32'(locked), 32'd1);
      @(negedge clk);

      // Backpressure holds output and freezes the keystream.
      seed_load(32'h00000001);
      xfer("bp_w0", 32'hFFFFFFFF, 32'hFFFFFFFE);
      stream.out_ready = 1'b0;
      stream.in_data   = 32'h0;
      for (int i = 0; i < 4; i++) begin
         #1 chk("bp_in_ready", 32'(stream.in_ready), 32'd0);
         @(negedge clk);
         chk("bp_hold_valid", 32'(stream.out_valid), 32'd1);
         chk("bp_hold_data", stream.out_data, 32'hFFFFFFFE);
      end
      stream.out_ready = 1'b1;
      xfer("bp_w1", 32'h00000000, 32'h80200003);
      stream.in_valid = 1'b0;
      @(negedge clk);

      // Reseed collides with an offered word: seed wins.
      seed_load(32'h00000001);
      xfer("rs_w0", 32'hFFFFFFFF, 32'hFFFFFFFE);
      xfer("rs_w1", 32'hFFFFFFFF, 32'h7FDFFFFC);
      xfer("rs_w2", 32'h00000000, 32'hC0300002);
      seed_valid     = 1'b1;
      seed           = 32'h00000001;
      stream.in_data = 32'h12345678;
      #1 chk("rs_collide_in_ready", 32'(stream.in_ready), 32'd0);
      @(negedge clk);
      seed_valid = 1'b0;
      chk("rs_collide_valid", 32'(stream.out_valid), 32'd0);
      chk("rs_collide_data", stream.out_data, 32'hC0300002);
      chk("rs_collide_count", 32'(word_count), 32'd0);
      xfer("rs_w3", 32'h00000000, 32'h00000001);
      chk("rs_count", 32'(word_count), 32'd1);

      // Counter saturates at all ones.
      stream.in_valid = 1'b1;
      stream.in_data  = 32'h0;
      repeat (20) @(negedge clk);
      chk("sat_count", 32'(word_count), 32'd15);
      stream.in_valid = 1'b0;
      @(negedge clk);

      // Asynchronous reset with a word pending.
      seed_load(32'h00000001);
      xfer("ar_w0", 32'hFFFFFFFF, 32'hFFFFFFFE);
      stream.in_valid  = 1'b0;
      stream.out_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("ar_out_valid", 32'(stream.out_valid), 32'd0);
      chk("ar_out_data", stream.out_data, 32'h0);
      chk("ar_locked", 32'(locked), 32'd0);
      chk("ar_count", 32'(word_count), 32'd0);
      chk("ar_in_ready", 32'(stream.in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      stream.out_ready = 1'b1;
      @(negedge clk);
      chk("ar_after_locked", 32'(locked), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
